// File: rtl/mem_stage_hs_pkg.sv
// Shared types for the handshaked memory stage: instruction word, memory
// control bundle, stage state encoding and ack-wait counter sizing.
package mem_stage_hs_pkg;

  typedef logic [15:0] uword;

  typedef struct packed {
    logic mem2r;  // load
    logic memwr;  // store
  } memc_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } memstage_state_t;

  localparam int unsigned MEM_WAIT_MAX = 15;
  localparam int unsigned MEM_WAIT_W   = $clog2(MEM_WAIT_MAX + 1);

  // A live instruction that touches memory (load, store or both).
  function automatic logic is_mem_op(input logic valid, input memc_t m);
    return valid && (m.mem2r || m.memwr);
  endfunction

endpackage

// File: rtl/mem_stage_hs_ctrl.sv
// mem_hs_ctrl: request/acknowledge state machine, upstream stall and
// (with MEM_STAGE_TIMEOUT_EN defined) the ack-wait timeout counter.
module mem_hs_ctrl
  import mem_stage_hs_pkg::*;
#(
  parameter int unsigned WAIT_MAX = MEM_WAIT_MAX
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_mem_op,
  input  logic            i_halt,
  input  logic            i_ack,
  output memstage_state_t o_state,
  output logic            o_accept,
  output logic            o_done,
  output logic            o_timeout,
  output logic            o_stall,
  output logic            o_mem_req,
  output logic            o_mem_err
);

  if (WAIT_MAX < 1) begin : g_bad_wait_max
    $error("mem_hs_ctrl: WAIT_MAX must be at least 1");
  end

  memstage_state_t r_state;
  memstage_state_t w_state_nxt;
  logic            w_timeout;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, accept/complete strobes and upstream stall
  always_comb begin
    w_state_nxt = r_state;
    o_accept    = 1'b0;
    o_done      = 1'b0;
    o_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_mem_op && !i_halt) begin
          o_accept    = 1'b1;
          o_stall     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        o_stall = !i_ack && !w_timeout;
        if (i_ack) begin
          o_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_MAX - 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_mem_err;

  // Fires on the wait cycle whose count would reach WAIT_MAX; an ack in
  // that same cycle takes priority.
  assign w_timeout = (r_state == S_WAIT) && !i_ack && (r_wait_cnt == LIMIT_M1);

  // Wait counter and sticky timeout flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      if (o_accept) begin
        r_wait_cnt <= '0;
      end else if ((r_state == S_WAIT) && !i_ack) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  assign o_mem_err = r_mem_err;
`else
  assign w_timeout = 1'b0;
  assign o_mem_err = 1'b0;
`endif

  assign o_state   = r_state;
  assign o_timeout = w_timeout;
  assign o_mem_req = (r_state == S_WAIT);

endmodule

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: EX->WB memory stage with a req/ack memory port.
// Holds the load-data mux, the captured request and the WB registers;
// sequencing lives in mem_hs_ctrl. Optional macro: MEM_STAGE_TIMEOUT_EN.
module mem_stage_hs
  import mem_stage_hs_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned HI_W     = 16,
  parameter int unsigned WAIT_MAX = MEM_WAIT_MAX
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  uword                     instruction,
  input  logic [HI_W+DATA_W-1:0]   alu,
  input  memc_t                    memc,
  input  logic [DATA_W-1:0]        r1_data,
  input  logic                     r0_en,
  input  logic                     halt_sys,
  output logic                     stall_out,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     valid_out,
  output logic [HI_W+DATA_W-1:0]   data,
  output logic [DATA_W-1:0]        r1_data_out,
  output memc_t                    out_memc,
  output logic                     out_r0_en,
  output uword                     instruction_out,
  output logic                     mem_err
);

  localparam int unsigned ALU_W = HI_W + DATA_W;

  if (ADDR_W > ALU_W) begin : g_bad_addr_w
    $error("mem_stage_hs: ADDR_W must not exceed HI_W+DATA_W");
  end

  memstage_state_t   w_state;
  logic              w_is_mem;
  logic              w_accept;
  logic              w_done;
  logic              w_timeout;
  logic              w_finish;
  logic              w_pass;
  logic [DATA_W-1:0] w_lo_mem;

  // Request captured at the accept edge; upstream changes are ignored after.
  uword              r_cap_instr;
  logic [ALU_W-1:0]  r_cap_alu;
  memc_t             r_cap_memc;
  logic [DATA_W-1:0] r_cap_r1;
  logic              r_cap_r0;

  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              r_valid_out;
  logic [ALU_W-1:0]  r_data;
  logic [DATA_W-1:0] r_r1_out;
  memc_t             r_memc_out;
  logic              r_r0_out;
  uword              r_instr_out;

  assign w_is_mem = is_mem_op(valid_in, memc);
  assign w_finish = w_done || w_timeout;
  assign w_pass   = (w_state == S_IDLE) && valid_in && !halt_sys && !w_is_mem;

  mem_hs_ctrl #(
    .WAIT_MAX (WAIT_MAX)
  ) u_ctrl (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_mem_op  (w_is_mem),
    .i_halt    (halt_sys),
    .i_ack     (mem_ack),
    .o_state   (w_state),
    .o_accept  (w_accept),
    .o_done    (w_done),
    .o_timeout (w_timeout),
    .o_stall   (stall_out),
    .o_mem_req (mem_req),
    .o_mem_err (mem_err)
  );

  // Low-lane result of a finished request: load data only for a pure load,
  // zero on timeout, otherwise the captured ALU low lane.
  always_comb begin
    w_lo_mem = r_cap_alu[DATA_W-1:0];
    if (w_timeout) begin
      w_lo_mem = '0;
    end else if (r_cap_memc.mem2r && !r_cap_memc.memwr) begin
      w_lo_mem = mem_rdata;
    end
  end

  // Request capture and WB pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_instr <= '0;
      r_cap_alu   <= '0;
      r_cap_memc  <= '0;
      r_cap_r1    <= '0;
      r_cap_r0    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_valid_out <= 1'b0;
      r_data      <= '0;
      r_r1_out    <= '0;
      r_memc_out  <= '0;
      r_r0_out    <= 1'b0;
      r_instr_out <= '0;
    end else begin
      if (w_accept) begin
        r_cap_instr <= instruction;
        r_cap_alu   <= alu;
        r_cap_memc  <= memc;
        r_cap_r1    <= r1_data;
        r_cap_r0    <= r0_en;
        r_mem_we    <= memc.memwr;
        r_mem_addr  <= alu[ADDR_W-1:0];
        r_mem_wdata <= r1_data;
        r_valid_out <= 1'b0;
      end else if (w_finish) begin
        r_data      <= {r_cap_alu[ALU_W-1:DATA_W], w_lo_mem};
        r_r1_out    <= r_cap_r1;
        r_memc_out  <= r_cap_memc;
        r_r0_out    <= r_cap_r0;
        r_instr_out <= r_cap_instr;
        r_valid_out <= 1'b1;
      end else if (w_pass) begin
        r_data      <= alu;
        r_r1_out    <= r1_data;
        r_memc_out  <= memc;
        r_r0_out    <= r0_en;
        r_instr_out <= instruction;
        r_valid_out <= 1'b1;
      end else begin
        r_valid_out <= 1'b0;
      end
    end
  end

  assign mem_we          = r_mem_we;
  assign mem_addr        = r_mem_addr;
  assign mem_wdata       = r_mem_wdata;
  assign valid_out       = r_valid_out;
  assign data            = r_data;
  assign r1_data_out     = r_r1_out;
  assign out_memc        = r_memc_out;
  assign out_r0_en       = r_r0_out;
  assign instruction_out = r_instr_out;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Bench for mem_stage_hs: directed cycle table, then randomized traffic
// compared against a transaction-level reference model.
module tb_mem_stage_hs;
  import mem_stage_hs_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  uword        instruction;
  logic [31:0] alu;
  memc_t       memc;
  logic [15:0] r1_data;
  logic        r0_en;
  logic        halt_sys;
  logic        stall_out;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        valid_out;
  logic [31:0] data;
  logic [15:0] r1_data_out;
  memc_t       out_memc;
  logic        out_r0_en;
  uword        instruction_out;
  logic        mem_err;

  int n_chk = 0;
  int n_err = 0;

  mem_stage_hs #(
    .DATA_W   (16),
    .ADDR_W   (16),
    .HI_W     (16),
    .WAIT_MAX (15)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_in        (valid_in),
    .instruction     (instruction),
    .alu             (alu),
    .memc            (memc),
    .r1_data         (r1_data),
    .r0_en           (r0_en),
    .halt_sys        (halt_sys),
    .stall_out       (stall_out),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .valid_out       (valid_out),
    .data            (data),
    .r1_data_out     (r1_data_out),
    .out_memc        (out_memc),
    .out_r0_en       (out_r0_en),
    .instruction_out (instruction_out),
    .mem_err         (mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        rst;
    logic        vin;
    logic [15:0] instr;
    logic [31:0] alu;
    logic [1:0]  memc;   // {mem2r, memwr}
    logic [15:0] r1;
    logic        halt;
    logic        ack;
    logic [15:0] rdata;
    logic        e_stall;
    logic        e_vout;
    logic        e_req;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic [31:0] e_data;
  } vec_t;

  localparam int NV = 21;
  vec_t tv [NV];

  // ---------------- reference model ----------------
  typedef struct {
    uword        instr;
    logic [31:0] alu;
    memc_t       memc;
    logic [15:0] r1;
    logic        r0;
  } op_t;

  op_t         pend_q[$];
  logic        m_vout, m_we, m_r0;
  logic [31:0] m_data;
  logic [15:0] m_r1, m_addr, m_wdata;
  memc_t       m_memc;
  uword        m_instr;

  task automatic model_clear();
    pend_q.delete();
    m_vout = 0; m_we = 0; m_r0 = 0; m_data = '0; m_r1 = '0;
    m_addr = '0; m_wdata = '0; m_memc = '0; m_instr = '0;
  endtask

  task automatic model_publish(input op_t p, input logic [15:0] lo);
    m_data  = {p.alu[31:16], lo};
    m_r1    = p.r1;
    m_memc  = p.memc;
    m_r0    = p.r0;
    m_instr = p.instr;
    m_vout  = 1'b1;
  endtask

  function automatic logic model_stall();
    if (pend_q.size() != 0) return !mem_ack;
    return valid_in && (memc != 2'b00) && !halt_sys;
  endfunction

  // What the WB/memory-port registers hold after the coming edge.
  task automatic model_edge();
    op_t cur;
    op_t p;
    cur.instr = instruction; cur.alu = alu; cur.memc = memc;
    cur.r1 = r1_data; cur.r0 = r0_en;
    if (rst) begin
      model_clear();
    end else if (pend_q.size() != 0) begin
      if (mem_ack) begin
        p = pend_q.pop_front();
        model_publish(p, (p.memc == 2'b10) ? mem_rdata : p.alu[15:0]);
      end else begin
        m_vout = 1'b0;
      end
    end else if (halt_sys || !valid_in) begin
      m_vout = 1'b0;
    end else if (memc != 2'b00) begin
      pend_q.push_back(cur);
      m_we    = memc.memwr;
      m_addr  = alu[15:0];
      m_wdata = r1_data;
      m_vout  = 1'b0;
    end else begin
      model_publish(cur, alu[15:0]);
    end
  endtask

  task automatic check_model(input int c);
    string s;
    s = $sformatf("rnd%0d", c);
    chk({s, " valid_out"},       valid_out,       m_vout);
    chk({s, " mem_req"},         mem_req,         pend_q.size() != 0);
    chk({s, " mem_we"},          mem_we,          m_we);
    chk({s, " mem_addr"},        mem_addr,        m_addr);
    chk({s, " mem_wdata"},       mem_wdata,       m_wdata);
    chk({s, " data"},            data,            m_data);
    chk({s, " r1_data_out"},     r1_data_out,     m_r1);
    chk({s, " out_memc"},        out_memc,        m_memc);
    chk({s, " out_r0_en"},       out_r0_en,       m_r0);
    chk({s, " instruction_out"}, instruction_out, m_instr);
    chk({s, " mem_err"},         mem_err,         1'b0);
  endtask

  initial begin
    //          rst vin instr     alu            memc  r1        hlt ack rdata     | st vo rq we addr      wdata     data
    tv[0]  = '{0, 1, 16'h1001, 32'h0001_0042, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000, 32'h0001_0042};
    tv[1]  = '{0, 0, 16'h0000, 32'h0000_0000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 32'h0001_0042};
    tv[2]  = '{0, 1, 16'h2002, 32'h0000_0010, 2'b10, 16'h0000, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h0010, 16'h0000, 32'h0001_0042};
    tv[3]  = '{0, 1, 16'h2002, 32'h0000_0010, 2'b10, 16'h0000, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h0010, 16'h0000, 32'h0001_0042};
    tv[4]  = '{0, 1, 16'h2002, 32'h0000_0010, 2'b10, 16'h0000, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h0010, 16'h0000, 32'h0001_0042};
    tv[5]  = '{0, 1, 16'h2002, 32'h0000_0010, 2'b10, 16'h0000, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h0010, 16'h0000, 32'h0001_0042};
    tv[6]  = '{0, 1, 16'h2002, 32'h0000_0010, 2'b10, 16'h0000, 0, 1, 16'hBEEF, 0, 1, 0, 0, 16'h0010, 16'h0000, 32'h0000_BEEF};
    tv[7]  = '{0, 0, 16'h0000, 32'h0000_0000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0010, 16'h0000, 32'h0000_BEEF};
    tv[8]  = '{0, 1, 16'h3003, 32'h0000_0020, 2'b01, 16'h1234, 0, 0, 16'h0000, 1, 0, 1, 1, 16'h0020, 16'h1234, 32'h0000_BEEF};
    tv[9]  = '{0, 1, 16'h3003, 32'h0000_0020, 2'b01, 16'h1234, 0, 0, 16'h0000, 1, 0, 1, 1, 16'h0020, 16'h1234, 32'h0000_BEEF};
    tv[10] = '{0, 1, 16'h3003, 32'h0000_0020, 2'b01, 16'h1234, 0, 1, 16'hFFFF, 0, 1, 0, 1, 16'h0020, 16'h1234, 32'h0000_0020};
    tv[11] = '{0, 1, 16'h4004, 32'h0000_0030, 2'b10, 16'h5555, 1, 0, 16'h0000, 0, 0, 0, 1, 16'h0020, 16'h1234, 32'h0000_0020};
    tv[12] = '{0, 1, 16'h4004, 32'h0000_0030, 2'b10, 16'h5555, 1, 0, 16'h0000, 0, 0, 0, 1, 16'h0020, 16'h1234, 32'h0000_0020};
    tv[13] = '{0, 1, 16'h4004, 32'h0000_0030, 2'b10, 16'h5555, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h0030, 16'h5555, 32'h0000_0020};
    tv[14] = '{0, 1, 16'h4004, 32'h0000_0030, 2'b10, 16'h5555, 0, 1, 16'h7777, 0, 1, 0, 0, 16'h0030, 16'h5555, 32'h0000_7777};
    tv[15] = '{0, 1, 16'h5005, 32'h0003_0040, 2'b11, 16'hAAAA, 0, 0, 16'h0000, 1, 0, 1, 1, 16'h0040, 16'hAAAA, 32'h0000_7777};
    tv[16] = '{0, 1, 16'h5005, 32'h0003_0040, 2'b11, 16'hAAAA, 0, 1, 16'h9999, 0, 1, 0, 1, 16'h0040, 16'hAAAA, 32'h0003_0040};
    tv[17] = '{0, 1, 16'h6006, 32'h0000_0050, 2'b10, 16'h0000, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h0050, 16'h0000, 32'h0003_0040};
    tv[18] = '{1, 0, 16'h0000, 32'h0000_0000, 2'b00, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 32'h0000_0000};
    tv[19] = '{0, 0, 16'h0000, 32'h0000_0000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 32'h0000_0000};
    tv[20] = '{0, 0, 16'h0000, 32'h0000_0000, 2'b00, 16'h0000, 0, 1, 16'h1111, 0, 0, 0, 0, 16'h0000, 16'h0000, 32'h0000_0000};

    rst = 1; valid_in = 0; instruction = '0; alu = '0; memc = '0; r1_data = '0;
    r0_en = 0; halt_sys = 0; mem_ack = 0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid_out",       valid_out,       1'b0);
    chk("reset mem_req",         mem_req,         1'b0);
    chk("reset mem_we",          mem_we,          1'b0);
    chk("reset mem_addr",        mem_addr,        16'h0);
    chk("reset mem_wdata",       mem_wdata,       16'h0);
    chk("reset data",            data,            32'h0);
    chk("reset r1_data_out",     r1_data_out,     16'h0);
    chk("reset out_memc",        out_memc,        2'b00);
    chk("reset out_r0_en",       out_r0_en,       1'b0);
    chk("reset instruction_out", instruction_out, 16'h0);
    chk("reset mem_err",         mem_err,         1'b0);
    chk("reset stall_out",       stall_out,       1'b0);
    rst = 0;

    for (int i = 0; i < NV; i++) begin
      rst = tv[i].rst; valid_in = tv[i].vin; instruction = tv[i].instr;
      alu = tv[i].alu; memc = tv[i].memc; r1_data = tv[i].r1; r0_en = 1'b0;
      halt_sys = tv[i].halt; mem_ack = tv[i].ack; mem_rdata = tv[i].rdata;
      #2;
      chk($sformatf("row%0d stall_out", i), stall_out, tv[i].e_stall);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d valid_out", i), valid_out, tv[i].e_vout);
      chk($sformatf("row%0d mem_req", i),   mem_req,   tv[i].e_req);
      chk($sformatf("row%0d mem_we", i),    mem_we,    tv[i].e_we);
      chk($sformatf("row%0d mem_addr", i),  mem_addr,  tv[i].e_addr);
      chk($sformatf("row%0d mem_wdata", i), mem_wdata, tv[i].e_wdata);
      chk($sformatf("row%0d data", i),      data,      tv[i].e_data);
    end

    // Pass-through copies of a plain ALU op
    rst = 0; valid_in = 1; instruction = 16'hC0DE; alu = 32'hDEAD_0007;
    memc = 2'b00; r1_data = 16'h4321; r0_en = 1; halt_sys = 0; mem_ack = 0;
    @(posedge clk);
    #1;
    chk("pass instruction_out", instruction_out, 16'hC0DE);
    chk("pass r1_data_out",     r1_data_out,     16'h4321);
    chk("pass out_r0_en",       out_r0_en,       1'b1);
    chk("pass data",            data,            32'hDEAD_0007);

    // Randomized traffic against the model, starting from a fresh reset
    rst = 1; valid_in = 0; mem_ack = 0;
    model_clear();
    @(posedge clk);
    #1;
    for (int c = 0; c < 500; c++) begin
      logic e_stall;
      rst         = ($urandom_range(0, 59) == 0);
      valid_in    = ($urandom_range(0, 3) != 0);
      instruction = 16'($urandom);
      alu         = $urandom;
      memc        = 2'($urandom_range(0, 3));
      r1_data     = 16'($urandom);
      r0_en       = 1'($urandom);
      halt_sys    = ($urandom_range(0, 5) == 0);
      mem_ack     = ($urandom_range(0, 2) == 0);
      mem_rdata   = 16'($urandom);
      #2;
      e_stall = model_stall();
      chk($sformatf("rnd%0d stall_out", c), stall_out, e_stall);
      model_edge();
      @(posedge clk);
      #1;
      check_model(c);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
